// File: rtl/fwd_operand_stage.sv
// ============================================================================
// Module      : fwd_operand_stage
// Description : ID/EX operand select with EX/MEM/WB forwarding, a load-use
//               stall FSM, and a valid/ready registered output.
//               Optional macro FWD_STALL_CNT_EN adds a saturating stall_cycles
//               counter port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_operand_stage #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*ADDR_W-1:0]  src_addr,
  input  logic [NSRC*WIDTH-1:0]   src_rf,
  input  logic                    ex_we,
  input  logic [ADDR_W-1:0]       ex_addr,
  input  logic [WIDTH-1:0]        ex_data,
  input  logic                    ex_ld,
  input  logic                    mem_we,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [WIDTH-1:0]        mem_data,
  input  logic                    wb_we,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [WIDTH-1:0]        wb_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NSRC*WIDTH-1:0]   out_data,
  output logic [NSRC*2-1:0]       out_sel,
  output logic                    stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam int CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [NSRC*WIDTH-1:0]  sel_data;
  logic [NSRC*2-1:0]      sel_code;
  logic [NSRC-1:0]        op_haz;
  logic                   hazard;

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_sel
      logic [ADDR_W-1:0] a;
      logic [WIDTH-1:0]  d;
      logic [1:0]        c;
      assign a = src_addr[i*ADDR_W +: ADDR_W];

      // A load in EX has no data yet, so it is not a forwarding source.
      always_comb begin
        d = src_rf[i*WIDTH +: WIDTH];
        c = 2'd0;
        if (a == '0) begin
          d = '0;
          c = 2'd0;
        end else if (ex_we && !ex_ld && ex_addr == a) begin
          d = ex_data;
          c = 2'd1;
        end else if (mem_we && mem_addr == a) begin
          d = mem_data;
          c = 2'd2;
        end else if (wb_we && wb_addr == a) begin
          d = wb_data;
          c = 2'd3;
        end
      end

      assign sel_data[i*WIDTH +: WIDTH] = d;
      assign sel_code[i*2 +: 2]         = c;
      assign op_haz[i] = (a != '0) && ex_we && ex_ld && (ex_addr == a);
    end
  endgenerate

  assign hazard   = in_valid && (|op_haz);
  assign stall    = (state == STALL);
  assign in_ready = (state == RUN) && !hazard && !flush && (!out_valid || out_ready);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (cnt == '0) state_nxt = RUN;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= sel_code;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && stall_cycles != 32'hFFFF_FFFF)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_operand_stage.sv
// ============================================================================
// Module      : tb_fwd_operand_stage
// Description : Directed self-checking bench for fwd_operand_stage
//               (LOAD_LAT=2). Honours FWD_STALL_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [9:0]  src_addr;
  logic [63:0] src_rf;
  logic        ex_we, ex_ld, mem_we, wb_we;
  logic [4:0]  ex_addr, mem_addr, wb_addr;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        out_valid, out_ready, stall;
  logic [63:0] out_data;
  logic [3:0]  out_sel;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  fwd_operand_stage #(.WIDTH(32), .ADDR_W(5), .NSRC(2), .LOAD_LAT(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .src_addr(src_addr), .src_rf(src_rf),
    .ex_we(ex_we), .ex_addr(ex_addr), .ex_data(ex_data), .ex_ld(ex_ld),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .stall(stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writers();
    ex_we = 0; ex_ld = 0; ex_addr = 0; ex_data = 0;
    mem_we = 0; mem_addr = 0; mem_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    src_addr = 0; src_rf = 0;
    clear_writers();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_sel !== 4'd0) begin errors++; $display("FAIL reset_sel got %h exp 0", out_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    reset = 0;
    tick();
  endtask

  task automatic test_rf_select();
    src_addr = {5'd9, 5'd8}; src_rf = {32'h99, 32'h88};
    in_valid = 1; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== {32'h99, 32'h88}) begin errors++; $display("FAIL rf_data got %h exp %h", out_data, {32'h99, 32'h88}); end
    checks++; if (out_sel !== 4'b0000) begin errors++; $display("FAIL rf_sel got %b exp 0000", out_sel); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_priority();
    src_addr = {5'd9, 5'd8}; src_rf = {32'h99, 32'h88};
    ex_we = 1;  ex_addr = 8;  ex_data = 32'hA;
    mem_we = 1; mem_addr = 8; mem_data = 32'hB;
    wb_we = 1;  wb_addr = 8;  wb_data = 32'hC;
    in_valid = 1; out_ready = 1;
    tick();
    checks++; if (out_data !== {32'h99, 32'hA}) begin errors++; $display("FAIL prio_ex_data got %h exp %h", out_data, {32'h99, 32'hA}); end
    checks++; if (out_sel !== 4'b0001) begin errors++; $display("FAIL prio_ex_sel got %b exp 0001", out_sel); end
    ex_we = 0;
    tick();
    checks++; if (out_data !== {32'h99, 32'hB}) begin errors++; $display("FAIL prio_mem_data got %h exp %h", out_data, {32'h99, 32'hB}); end
    checks++; if (out_sel !== 4'b0010) begin errors++; $display("FAIL prio_mem_sel got %b exp 0010", out_sel); end
    mem_we = 0;
    tick();
    checks++; if (out_data !== {32'h99, 32'hC}) begin errors++; $display("FAIL prio_wb_data got %h exp %h", out_data, {32'h99, 32'hC}); end
    checks++; if (out_sel !== 4'b0011) begin errors++; $display("FAIL prio_wb_sel got %b exp 0011", out_sel); end
    // both operands forwarded from the same stage
    src_addr = {5'd8, 5'd8};
    tick();
    checks++; if (out_data !== {32'hC, 32'hC}) begin errors++; $display("FAIL prio_both_data got %h exp %h", out_data, {32'hC, 32'hC}); end
    checks++; if (out_sel !== 4'b1111) begin errors++; $display("FAIL prio_both_sel got %b exp 1111", out_sel); end
    in_valid = 0; clear_writers();
    tick();
  endtask

  task automatic test_zero_reg();
    src_addr = {5'd9, 5'd0}; src_rf = {32'h99, 32'h55};
    ex_we = 1; ex_addr = 0; ex_data = 32'h5;
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0;
    checks++; if (out_data !== {32'h99, 32'h0}) begin errors++; $display("FAIL zero_data got %h exp %h", out_data, {32'h99, 32'h0}); end
    checks++; if (out_sel !== 4'b0000) begin errors++; $display("FAIL zero_sel got %b exp 0000", out_sel); end
    clear_writers();
    tick();
  endtask

  task automatic test_load_use();
    src_addr = {5'd8, 5'd9}; src_rf = {32'h88, 32'h99};
    ex_we = 1; ex_ld = 1; ex_addr = 8; ex_data = 32'hDEAD;
    in_valid = 1; out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_detect_ready got %b exp 0", in_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_detect_stall got %b exp 0", stall); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_%0d got %b exp 1", k, stall); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_%0d got %b exp 0", k, in_ready); end
    end
    clear_writers();
    mem_we = 1; mem_addr = 8; mem_data = 32'h77;
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release_stall got %b exp 0", stall); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_no_capture got %b exp 0", out_valid); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lu_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== {32'h77, 32'h99}) begin errors++; $display("FAIL lu_data got %h exp %h", out_data, {32'h77, 32'h99}); end
    checks++; if (out_sel !== 4'b1000) begin errors++; $display("FAIL lu_sel got %b exp 1000", out_sel); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL lu_stall_cycles got %0d exp 2", stall_cycles); end
`endif
    clear_writers();
    tick();
  endtask

  task automatic test_backpressure_flush();
    src_addr = {5'd9, 5'd8}; src_rf = {32'h11, 32'h22};
    in_valid = 1; out_ready = 0;
    tick();
    src_rf = {32'h33, 32'h44};
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_%0d got %b exp 0", k, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_%0d got %b exp 1", k, out_valid); end
      checks++; if (out_data !== {32'h11, 32'h22}) begin errors++; $display("FAIL bp_hold_%0d got %h exp %h", k, out_data, {32'h11, 32'h22}); end
      tick();
    end
    ex_we = 1; ex_ld = 1; ex_addr = 8;
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_enter_stall got %b exp 1", stall); end
    flush = 1;
    tick();
    flush = 0; clear_writers(); in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", out_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %b exp 0", stall); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL fl_stall_cycles got %0d exp 3", stall_cycles); end
`endif
    // flush beats a capture in the same cycle
    out_ready = 1; in_valid = 1; flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_in_ready got %b exp 0", in_ready); end
    tick();
    flush = 0; in_valid = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_capture got %b exp 0", out_valid); end
    tick();
  endtask

  task automatic test_reset_again();
    src_addr = {5'd9, 5'd8}; src_rf = {32'h5A, 32'hA5};
    in_valid = 1; out_ready = 0;
    tick();
    ex_we = 1; ex_ld = 1; ex_addr = 9;
    tick();
    reset = 1; flush = 1;
    tick();
    reset = 0; flush = 0; in_valid = 0; clear_writers();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst2_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst2_data got %h exp 0", out_data); end
    checks++; if (out_sel !== 4'd0) begin errors++; $display("FAIL rst2_sel got %b exp 0", out_sel); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst2_stall got %b exp 0", stall); end
`ifdef FWD_STALL_CNT_EN
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst2_stall_cycles got %0d exp 0", stall_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_rf_select();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_backpressure_flush();
    test_reset_again();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
